// File: rtl/top10_sched_if.sv
// Handshake and sorter bundle for top10_sched: job input, result output and sorter control.
`default_nettype none

interface top10_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 16
);
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH*NUM_WORDS-1:0] in_data;
  logic                            flush;
  logic                            sort_rst;
  logic                            sort_en;
  logic [DATA_WIDTH*NUM_WORDS-1:0] sort_array;
  logic [DATA_WIDTH*10-1:0]        sort_vals;
  logic [59:0]                     sort_ids;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH*10-1:0]        out_vals;
  logic [59:0]                     out_ids;
  logic                            busy;

  modport slave (
    input  in_valid, in_data, flush, sort_vals, sort_ids, out_ready,
    output in_ready, sort_rst, sort_en, sort_array, out_valid, out_vals, out_ids, busy
  );

  modport master (
    output in_valid, in_data, flush, sort_vals, sort_ids, out_ready,
    input  in_ready, sort_rst, sort_en, sort_array, out_valid, out_vals, out_ids, busy
  );
endinterface

`default_nettype wire

// File: rtl/top10_sched.sv
// top10_sched: sequences one selection-sort job (clear, enable, capture, hold) for the top-10 sorter.
// Optional TOP10_SCHED_PERF_EN adds job_count and stall_cycles counters.
`default_nettype none

module top10_sched #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WORDS   = 16,
  parameter int SORT_CYCLES = 10*NUM_WORDS-45
) (
  input  logic               clk,
  input  logic               rst,
  top10_sched_if.slave       bus
`ifdef TOP10_SCHED_PERF_EN
  ,
  output logic [15:0]        job_count,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int CNT_W = $clog2(SORT_CYCLES+1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SORT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_sort_rst;
  logic [DATA_WIDTH*NUM_WORDS-1:0] r_sort_array;
  logic [DATA_WIDTH*10-1:0]        r_out_vals;
  logic [59:0]                     r_out_ids;
  logic                            r_out_valid;
  logic                            w_accept;
  logic                            w_abort;
  logic                            w_capture;
  logic                            w_release;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          w_accept = 1'b1;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (bus.flush) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next = S_SORT;
        end
      end
      S_SORT: begin
        if (bus.flush) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == CNT_W'(SORT_CYCLES-1)) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.flush) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        // flush and out_ready both retire the held result
        if (bus.flush || bus.out_ready) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_sort_rst   <= 1'b1;
      r_sort_array <= '0;
      r_out_vals   <= '0;
      r_out_ids    <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_sort_rst <= (w_next == S_CLEAR) || w_abort;
      if (r_state == S_SORT) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
      if (w_accept) r_sort_array <= bus.in_data;
      if (w_capture) begin
        r_out_vals  <= bus.sort_vals;
        r_out_ids   <= bus.sort_ids;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // in_ready is gated by reset so the block refuses jobs while held in reset
  assign bus.in_ready   = (r_state == S_IDLE) && rst;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sort_en    = (r_state == S_SORT);
  assign bus.sort_rst   = r_sort_rst;
  assign bus.sort_array = r_sort_array;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_vals   = r_out_vals;
  assign bus.out_ids    = r_out_ids;

`ifdef TOP10_SCHED_PERF_EN
  logic [15:0] r_job_count;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_job_count    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_state == S_HOLD && bus.out_ready) r_job_count <= r_job_count + 16'd1;
      if (r_state == S_HOLD && !bus.out_ready && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign job_count    = r_job_count;
  assign stall_cycles = r_stall_cycles;
`else
  // performance counters not built
`endif

endmodule

`default_nettype wire

// File: tb/tb_top10_sched.sv
// Directed bench for top10_sched with a behavioural sorter that only settles after SORT_CYCLES enables.
`default_nettype none

module tb_top10_sched;
  localparam int DW = 16;
  localparam int NW = 16;
  localparam int SC = 10*NW-45;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  top10_sched_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) sif ();

`ifdef TOP10_SCHED_PERF_EN
  logic [15:0] job_count;
  logic [15:0] stall_cycles;
`endif

  top10_sched #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .SORT_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (sif)
`ifdef TOP10_SCHED_PERF_EN
    ,
    .job_count    (job_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // sorter model: enable cycles since last clear; outputs are zero until fully sorted
  int              m_cnt = 0;
  logic [DW*10-1:0] m_vals;
  logic [59:0]      m_ids;
  logic [NW-1:0]    m_used;
  int               m_best;
  logic [DW-1:0]    m_bv;

  always @(posedge clk) begin
    if (sif.sort_rst)     m_cnt <= 0;
    else if (sif.sort_en) m_cnt <= m_cnt + 1;
  end

  always_comb begin
    m_vals = '0;
    m_ids  = '0;
    m_used = '0;
    m_best = 0;
    m_bv   = '0;
    for (int k = 0; k < 10; k++) begin
      m_best = -1;
      m_bv   = '0;
      for (int j = 0; j < NW; j++) begin
        if (!m_used[j] && (m_best < 0 || sif.sort_array[j*DW +: DW] > m_bv)) begin
          m_best = j;
          m_bv   = sif.sort_array[j*DW +: DW];
        end
      end
      m_used[m_best]      = 1'b1;
      m_vals[k*DW +: DW]  = m_bv;
      m_ids[k*6 +: 6]     = m_best[5:0];
    end
  end

  assign sif.sort_vals = (m_cnt >= SC) ? m_vals : '0;
  assign sif.sort_ids  = (m_cnt >= SC) ? m_ids  : '0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*NW-1:0] mk_lin(input int a, input int b);
    logic [DW*NW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) v[j*DW +: DW] = 16'(a + b*j);
    return v;
  endfunction

  // descending ramp: top words are the high indices for b>=0, low indices for b<0
  task automatic exp_top(input int a, input int b, output logic [DW*10-1:0] v, output logic [59:0] id);
    int j;
    v  = '0;
    id = '0;
    for (int k = 0; k < 10; k++) begin
      j = (b >= 0) ? (NW-1-k) : k;
      v[k*DW +: DW] = 16'(a + b*j);
      id[k*6 +: 6]  = 6'(j);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!sif.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!sif.out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_job(input int a, input int b, input int stall, input bit chk_ids, input string tag);
    int edges, n_en, n_rs, n;
    logic [DW*10-1:0] ev;
    logic [59:0]      ei;
    logic [DW*10-1:0] hv;
    logic [59:0]      hi;
    logic             bad;
    n = 0;
    while (!sif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, sif.in_ready, 1);
    sif.in_data   = mk_lin(a, b);
    sif.in_valid  = 1'b1;
    sif.out_ready = (stall == 0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    edges = 0; n_en = 0; n_rs = 0;
    while (!sif.out_valid && edges < 400) begin
      if (sif.sort_en)  n_en++;
      if (sif.sort_rst) n_rs++;
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, edges, SC+2);
    check({tag, "_en_cycles"}, n_en, SC);
    check({tag, "_clr_pulses"}, n_rs, 1);
    exp_top(a, b, ev, ei);
    check({tag, "_vals"}, sif.out_vals, ev);
    if (chk_ids) check({tag, "_ids"}, sif.out_ids, ei);
    if (stall > 0) begin
      hv = sif.out_vals; hi = sif.out_ids; bad = 1'b0;
      repeat (stall) begin
        if (sif.out_vals !== hv || sif.out_ids !== hi || sif.in_ready !== 1'b0 || sif.out_valid !== 1'b1)
          bad = 1'b1;
        @(negedge clk);
      end
      check({tag, "_hold_stable"}, bad, 0);
      sif.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_done_valid"}, sif.out_valid, 0);
    check({tag, "_done_ready"}, sif.in_ready, 1);
  endtask

  initial begin : main
    int n;
    logic seen;
    logic [DW*10-1:0] ev;
    logic [59:0]      ei;
    rst           = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.flush     = 1'b0;
    sif.out_ready = 1'b0;
    #12;
    check("rst_sort_rst", sif.sort_rst, 1);
    check("rst_sort_en", sif.sort_en, 0);
    check("rst_in_ready", sif.in_ready, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_vals", sif.out_vals, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_sort_rst", sif.sort_rst, 0);
    check("rel_in_ready", sif.in_ready, 1);

    // 1: ramp 3*j
    run_job(0, 3, 0, 1'b1, "t1");
    // 2: all ties
    run_job(100, 0, 0, 1'b0, "t2");

    // 3: consumer stalls 20 cycles
    reset_pulse();
    run_job(0, 3, 20, 1'b1, "t3");
`ifdef TOP10_SCHED_PERF_EN
    check("t3_stall_cycles", stall_cycles, 20);
`endif

    // 4: flush at SORT counter 50
    sif.in_data  = mk_lin(500, -1);
    sif.in_valid = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    n = 0;
    while (n < 51) begin
      @(negedge clk);
      if (sif.sort_en) n++;
    end
    sif.flush = 1'b1;
    @(negedge clk);
    sif.flush = 1'b0;
    check("t4_sort_en", sif.sort_en, 0);
    check("t4_sort_rst", sif.sort_rst, 1);
    check("t4_in_ready", sif.in_ready, 1);
    check("t4_busy", sif.busy, 0);
    seen = 1'b0;
    repeat (150) begin
      if (sif.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("t4_no_valid", seen, 0);
    run_job(0, 3, 0, 1'b1, "t4b");

    // 5: reset mid-SORT
    sif.in_data  = mk_lin(0, 3);
    sif.in_valid = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_sort_rst", sif.sort_rst, 1);
    check("t5_sort_en", sif.sort_en, 0);
    check("t5_in_ready", sif.in_ready, 0);
    check("t5_busy", sif.busy, 0);
    check("t5_out_valid", sif.out_valid, 0);
    check("t5_sort_array", sif.sort_array[159:0], 0);
    check("t5_out_vals", sif.out_vals, 0);
    check("t5_out_ids", sif.out_ids, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rel_sort_rst", sif.sort_rst, 0);
    run_job(500, -1, 0, 1'b1, "t5");

    // 6: back-to-back with in_valid held high
    reset_pulse();
    sif.out_ready = 1'b1;
    sif.in_data   = mk_lin(0, 3);
    sif.in_valid  = 1'b1;
    @(negedge clk);
    check("t6_a_clear", sif.sort_rst, 1);
    sif.in_data = mk_lin(1000, -7);
    wait_valid("t6_a");
    exp_top(0, 3, ev, ei);
    check("t6_a_vals", sif.out_vals, ev);
    check("t6_a_ids", sif.out_ids, ei);
    @(negedge clk);
    check("t6_idle_valid", sif.out_valid, 0);
    check("t6_idle_busy", sif.busy, 0);
    check("t6_idle_ready", sif.in_ready, 1);
    @(negedge clk);
    check("t6_b_busy", sif.busy, 1);
    check("t6_b_clear", sif.sort_rst, 1);
    sif.in_valid = 1'b0;
    wait_valid("t6_b");
    exp_top(1000, -7, ev, ei);
    check("t6_b_vals", sif.out_vals, ev);
    check("t6_b_ids", sif.out_ids, ei);
    @(negedge clk);
    check("t6_b_done", sif.out_valid, 0);
`ifdef TOP10_SCHED_PERF_EN
    check("t6_job_count", job_count, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
